// File: rtl/debug_uart_tx.sv
// debug_uart_tx: snapshots seven debug bytes on trigger and sends them as 8N1 UART bytes after SYNC_BYTE.
// Optional macro DEBUG_UART_CHECKSUM_EN appends a ninth byte (mod-256 sum of the snapshot).
module debug_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic [7:0] debug_port1,
  input  logic [7:0] debug_port2,
  input  logic [7:0] debug_port3,
  input  logic [7:0] debug_port4,
  input  logic [7:0] debug_port5,
  input  logic [7:0] debug_port6,
  input  logic [7:0] debug_port7,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  // state | meaning
  // IDLE  | line high, waiting for trigger
  // START | start bit (0) of the current byte
  // DATA  | data bit bit_idx of the current byte, LSB first
  // STOP  | stop bit (1) of the current byte
  // DONE  | one-cycle end-of-frame pulse; busy already low, trigger accepted
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

`ifdef DEBUG_UART_CHECKSUM_EN
  localparam int unsigned NUM_BYTES = 9;
`else
  localparam int unsigned NUM_BYTES = 8;
`endif

  localparam int unsigned     CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       BYTE_LAST = 4'(NUM_BYTES - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [3:0]       byte_idx;
  logic [7:0]       snap [7];
  logic [7:0]       cur_byte;
  logic             bit_end;

`ifdef DEBUG_UART_CHECKSUM_EN
  logic [7:0] checksum;
  assign checksum = snap[0] + snap[1] + snap[2] + snap[3] + snap[4] + snap[5] + snap[6];
`endif

  assign bit_end = (bit_cnt == BIT_LAST);

  always_comb begin
    cur_byte = SYNC_BYTE;
    case (byte_idx)
      4'd0:    cur_byte = SYNC_BYTE;
      4'd1:    cur_byte = snap[0];
      4'd2:    cur_byte = snap[1];
      4'd3:    cur_byte = snap[2];
      4'd4:    cur_byte = snap[3];
      4'd5:    cur_byte = snap[4];
      4'd6:    cur_byte = snap[5];
      4'd7:    cur_byte = snap[6];
`ifdef DEBUG_UART_CHECKSUM_EN
      4'd8:    cur_byte = checksum;
`endif
      default: cur_byte = SYNC_BYTE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      for (int i = 0; i < 7; i++) snap[i] <= '0;
    end else begin
      case (state)
        // DONE behaves like IDLE so a trigger in the done cycle starts the next frame
        IDLE, DONE: begin
          if (trigger) begin
            state    <= START;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            snap[0]  <= debug_port1;
            snap[1]  <= debug_port2;
            snap[2]  <= debug_port3;
            snap[3]  <= debug_port4;
            snap[4]  <= debug_port5;
            snap[5]  <= debug_port6;
            snap[6]  <= debug_port7;
          end else begin
            state <= IDLE;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (byte_idx == BYTE_LAST) begin
              state <= DONE;
            end else begin
              byte_idx <= byte_idx + 4'd1;
              state    <= START;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = cur_byte[bit_idx];
      default: tx = 1'b1;
    endcase
  end

  assign busy = (state == START) || (state == DATA) || (state == STOP);
  assign done = (state == DONE);

endmodule
